// File: rtl/launch_adc_pkg.sv
// Shared types and constants for the igniter ohm-meter ADC front end.
// Holds the channel map, divider latency and the pair collector state encoding.
package launch_adc_pkg;

  typedef logic [11:0] adc_code_t;
  typedef logic [4:0]  adc_chan_t;

  localparam adc_chan_t ADC_CH_IGN_V     = 5'd1;
  localparam adc_chan_t ADC_CH_IGN_I     = 5'd2;
  localparam int        OHM_DIV_LATENCY  = 16;
  localparam int        ADC_PAIR_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    COL_IDLE   = 2'd0,
    COL_HAVE_V = 2'd1,
    COL_HAVE_I = 2'd2
  } collect_state_e;

endpackage

// File: rtl/adc_pair_sched_if.sv
// Sample-in / pair-out bus of the ADC pair scheduler.
// master = sample producer and pair consumer, slave = the scheduler.
interface adc_pair_sched_if;
  import launch_adc_pkg::*;

  // adc_valid qualifies adc_chan/adc_data for exactly one cycle and there is no
  // ready: every sample is taken. pair_valid is a one-cycle strobe and
  // v_out/i_out hold their value until the next strobe.
  logic      adc_valid;
  adc_chan_t adc_chan;
  adc_code_t adc_data;
  logic      pair_valid;
  adc_code_t v_out;
  adc_code_t i_out;

  modport master (
    output adc_valid, adc_chan, adc_data,
    input  pair_valid, v_out, i_out
  );

  modport slave (
    input  adc_valid, adc_chan, adc_data,
    output pair_valid, v_out, i_out
  );

endinterface

// File: rtl/adc_pair_avg4.sv
// Four-pair averaging accumulator; only instantiated when ADC_AVG4_EN is defined.
// out_valid fires combinationally with the 4th completed pair, carrying sum>>2.
module adc_pair_avg4
  import launch_adc_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      in_valid,
  input  adc_code_t in_v,
  input  adc_code_t in_i,
  output logic      out_valid,
  output adc_code_t out_v,
  output adc_code_t out_i
);

  logic [13:0] sum_v_q, sum_i_q;
  logic [13:0] sum_v_d, sum_i_d;
  logic [1:0]  cnt_q;

  // Four 12-bit codes never exceed 14 bits, so the running sum cannot wrap.
  always_comb begin
    sum_v_d   = sum_v_q + 14'(in_v);
    sum_i_d   = sum_i_q + 14'(in_i);
    out_valid = in_valid && (cnt_q == 2'd3);
    out_v     = sum_v_d[13:2];
    out_i     = sum_i_d[13:2];
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      sum_v_q <= '0;
      sum_i_q <= '0;
      cnt_q   <= '0;
    end else if (in_valid) begin
      if (cnt_q == 2'd3) begin
        sum_v_q <= '0;
        sum_i_q <= '0;
        cnt_q   <= '0;
      end else begin
        sum_v_q <= sum_v_d;
        sum_i_q <= sum_i_d;
        cnt_q   <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/adc_pair_sched.sv
// Pairs V/I ADC samples and paces pairs to the resistance divider's pipeline.
// Optional feature: define ADC_AVG4_EN to average every four pairs before issue.
module adc_pair_sched
  import launch_adc_pkg::*;
#(
  parameter adc_chan_t V_CHAN  = ADC_CH_IGN_V,
  parameter adc_chan_t I_CHAN  = ADC_CH_IGN_I,
  parameter int        HOLDOFF = OHM_DIV_LATENCY,
  parameter int        TIMEOUT = ADC_PAIR_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  adc_pair_sched_if.slave bus,
  output logic           timeout_err,
  output logic [7:0]     drop_cnt,
  output collect_state_e state_dbg
);

  localparam int AGE_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  collect_state_e   state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  adc_code_t        half_v_q, half_v_d, half_i_q, half_i_d;
  logic             is_v, is_i, complete, expire;
  adc_code_t        cmp_v, cmp_i;

  logic             wr_valid;
  adc_code_t        wr_v, wr_i;

  logic             buf_full_q;
  adc_code_t        buf_v_q, buf_i_q;
  logic [HOLD_W-1:0] hold_q;
  logic             issue;
  logic             pair_valid_q;
  adc_code_t        v_out_q, i_out_q;

  assign is_v = bus.adc_valid && (bus.adc_chan == V_CHAN);
  assign is_i = bus.adc_valid && (bus.adc_chan == I_CHAN);

  // Completion is tested before expiry so a partner arriving on the last
  // allowed cycle still forms a pair.
  always_comb begin
    state_d  = state_q;
    age_d    = age_q;
    half_v_d = half_v_q;
    half_i_d = half_i_q;
    complete = 1'b0;
    expire   = 1'b0;
    cmp_v    = half_v_q;
    cmp_i    = half_i_q;
    unique case (state_q)
      COL_IDLE: begin
        if (is_v) begin
          state_d  = COL_HAVE_V;
          half_v_d = bus.adc_data;
          age_d    = '0;
        end else if (is_i) begin
          state_d  = COL_HAVE_I;
          half_i_d = bus.adc_data;
          age_d    = '0;
        end
      end
      COL_HAVE_V: begin
        if (is_i) begin
          complete = 1'b1;
          cmp_i    = bus.adc_data;
          state_d  = COL_IDLE;
        end else if (age_q == AGE_W'(TIMEOUT)) begin
          expire  = 1'b1;
          state_d = COL_IDLE;
        end else begin
          age_d = age_q + 1'b1;
          if (is_v) half_v_d = bus.adc_data;
        end
      end
      COL_HAVE_I: begin
        if (is_v) begin
          complete = 1'b1;
          cmp_v    = bus.adc_data;
          state_d  = COL_IDLE;
        end else if (age_q == AGE_W'(TIMEOUT)) begin
          expire  = 1'b1;
          state_d = COL_IDLE;
        end else begin
          age_d = age_q + 1'b1;
          if (is_i) half_i_d = bus.adc_data;
        end
      end
      default: state_d = COL_IDLE;
    endcase
  end

`ifdef ADC_AVG4_EN
  adc_pair_avg4 u_avg4 (
    .clk       (clk),
    .reset     (reset),
    .clear     (expire),
    .in_valid  (complete),
    .in_v      (cmp_v),
    .in_i      (cmp_i),
    .out_valid (wr_valid),
    .out_v     (wr_v),
    .out_i     (wr_i)
  );
`else
  assign wr_valid = complete;
  assign wr_v     = cmp_v;
  assign wr_i     = cmp_i;
`endif

  assign issue = buf_full_q && (hold_q == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= COL_IDLE;
      age_q        <= '0;
      half_v_q     <= '0;
      half_i_q     <= '0;
      buf_full_q   <= 1'b0;
      buf_v_q      <= '0;
      buf_i_q      <= '0;
      hold_q       <= '0;
      pair_valid_q <= 1'b0;
      v_out_q      <= '0;
      i_out_q      <= '0;
      timeout_err  <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      age_q        <= age_d;
      half_v_q     <= half_v_d;
      half_i_q     <= half_i_d;
      pair_valid_q <= issue;
      if (expire) timeout_err <= 1'b1;

      if (issue) begin
        v_out_q <= buf_v_q;
        i_out_q <= buf_i_q;
        hold_q  <= HOLD_W'(HOLDOFF - 1);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end

      // A write in the issue cycle refills the slot the older pair just left.
      if (wr_valid) begin
        buf_v_q    <= wr_v;
        buf_i_q    <= wr_i;
        buf_full_q <= 1'b1;
        if (buf_full_q && !issue && (drop_cnt != 8'hFF))
          drop_cnt <= drop_cnt + 8'd1;
      end else if (issue) begin
        buf_full_q <= 1'b0;
      end
    end
  end

  assign bus.pair_valid = pair_valid_q;
  assign bus.v_out      = v_out_q;
  assign bus.i_out      = i_out_q;
  assign state_dbg      = state_q;

endmodule
